// File: rtl/board_memory_arbiter.sv
// Round-robin request/grant arbiter for the single-port 64-square board RAM.
// Grants bursts to one of four agents and flags when each agent's read data is on piece_read.
module board_memory_arbiter #(
    parameter int ADDR_W    = 6,
    parameter int DATA_W    = 4,
    parameter int MAX_BURST = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            req,
    input  logic [4*ADDR_W-1:0]   addr_in,
    input  logic                  datapath_we,
    input  logic [DATA_W-1:0]     datapath_wdata,
    output logic [3:0]            gnt,
    output logic [1:0]            memory_manage,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic                  ram_wren,
    output logic [DATA_W-1:0]     ram_wdata,
    output logic [3:0]            rd_valid,
    output logic                  busy
);

    typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

    localparam logic [7:0] BURST_SAT  = 8'(MAX_BURST);
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [3:0]  gnt_q, gnt_d;
    logic [3:0]  rd_valid_q, rd_valid_d;
    logic [1:0]  owner_q, owner_d;
    logic [1:0]  rr_q, rr_d;
    logic        busy_q, busy_d;
    logic [7:0]  burst_q, burst_d;

    logic        access;
    logic        is_write;
    logic        others_pending;
    logic        at_limit;
    logic [1:0]  winner;

    assign access         = (state_q == OWN) && req[owner_q];
    assign is_write       = access && (owner_q == 2'd2) && datapath_we;
    assign others_pending = |(req & ~gnt_q);
    // A solo owner saturates past the last slot, so compare with >= to still force release.
    assign at_limit       = burst_q >= BURST_LAST;

    always_comb begin : rr_search
        logic [1:0] idx;
        logic       found;
        idx    = rr_q;
        found  = 1'b0;
        winner = rr_q;
        for (int k = 0; k < 4; k++) begin
            idx = rr_q + 2'(k);
            if (!found && req[idx]) begin
                winner = idx;
                found  = 1'b1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        owner_d    = owner_q;
        rr_d       = rr_q;
        busy_d     = busy_q;
        burst_d    = burst_q;
        rd_valid_d = (access && !is_write) ? gnt_q : 4'b0000;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = OWN;
                    gnt_d   = 4'b0001 << winner;
                    owner_d = winner;
                    busy_d  = 1'b1;
                    burst_d = 8'd0;
                end
            end
            OWN: begin
                if (!access || (at_limit && others_pending)) begin
                    state_d = IDLE;
                    gnt_d   = 4'b0000;
                    busy_d  = 1'b0;
                    rr_d    = owner_q + 2'd1;
                    burst_d = 8'd0;
                end else if (burst_q < BURST_SAT) begin
                    burst_d = burst_q + 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            gnt_q      <= 4'b0000;
            owner_q    <= 2'd0;
            rr_q       <= 2'd0;
            busy_q     <= 1'b0;
            burst_q    <= 8'd0;
            rd_valid_q <= 4'b0000;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            owner_q    <= owner_d;
            rr_q       <= rr_d;
            busy_q     <= busy_d;
            burst_q    <= burst_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign gnt           = gnt_q;
    assign memory_manage = owner_q;
    assign busy          = busy_q;
    assign rd_valid      = rd_valid_q;
    assign ram_addr      = busy_q ? addr_in[owner_q*ADDR_W +: ADDR_W] : '0;
    assign ram_wren      = busy_q & gnt_q[2] & req[2] & datapath_we;
    assign ram_wdata     = datapath_wdata;

endmodule

// File: tb/tb_board_memory_arbiter.sv
// Directed bench for board_memory_arbiter with a small synchronous RAM model on the bus.
module tb_board_memory_arbiter;

    localparam int ADDR_W    = 6;
    localparam int DATA_W    = 4;
    localparam int MAX_BURST = 8;

    logic                clk = 1'b0;
    logic                reset;
    logic [3:0]          req;
    logic [4*ADDR_W-1:0] addr_in;
    logic                datapath_we;
    logic [DATA_W-1:0]   datapath_wdata;
    logic [3:0]          gnt;
    logic [1:0]          memory_manage;
    logic [ADDR_W-1:0]   ram_addr;
    logic                ram_wren;
    logic [DATA_W-1:0]   ram_wdata;
    logic [3:0]          rd_valid;
    logic                busy;

    logic [DATA_W-1:0]   mem [64];
    logic [DATA_W-1:0]   piece_read;

    int vec_cnt = 0;
    int err_cnt = 0;

    board_memory_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .reset(reset), .req(req), .addr_in(addr_in),
        .datapath_we(datapath_we), .datapath_wdata(datapath_wdata),
        .gnt(gnt), .memory_manage(memory_manage), .ram_addr(ram_addr),
        .ram_wren(ram_wren), .ram_wdata(ram_wdata), .rd_valid(rd_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_wren) mem[ram_addr] <= ram_wdata;
        piece_read <= mem[ram_addr];
    end

    task automatic cyc_begin();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_addr(input int i, input int a);
        addr_in[i*ADDR_W +: ADDR_W] = ADDR_W'(a);
    endtask

    task automatic do_reset();
        cyc_begin();
        reset = 1'b1;
        req   = 4'b0000;
        cyc_begin();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req = 4'b0000; addr_in = '0; datapath_we = 1'b0; datapath_wdata = '0;
        repeat (2) @(posedge clk);
        mid();
        vec_cnt++;
        if ({gnt, memory_manage, busy, rd_valid, ram_wren, ram_addr} !== 18'd0) begin
            err_cnt++;
            $display("FAIL reset_state: got %b required %b", {gnt, memory_manage, busy, rd_valid, ram_wren, ram_addr}, 18'd0);
        end
        cyc_begin();
        reset = 1'b0;
        mid();
        vec_cnt++;
        if ({gnt, busy, rd_valid} !== 9'd0) begin
            err_cnt++;
            $display("FAIL idle_after_reset: got %b required %b", {gnt, busy, rd_valid}, 9'd0);
        end
    endtask

    task automatic test_stream();
        int run;
        run = 0;
        cyc_begin();
        req = 4'b1000;
        mid();
        vec_cnt++;
        if (gnt !== 4'b0000) begin
            err_cnt++;
            $display("FAIL stream_latency: gnt got %b required %b", gnt, 4'b0000);
        end
        for (int k = 0; k < 64; k++) begin
            cyc_begin();
            set_addr(3, k);
            mid();
            vec_cnt++;
            if ({gnt, memory_manage, busy, ram_addr} !== {4'b1000, 2'd3, 1'b1, 6'(k)}) begin
                err_cnt++;
                $display("FAIL stream_grant k=%0d: got %b required %b", k, {gnt, memory_manage, busy, ram_addr}, {4'b1000, 2'd3, 1'b1, 6'(k)});
            end
            vec_cnt++;
            if (rd_valid !== ((k == 0) ? 4'b0000 : 4'b1000)) begin
                err_cnt++;
                $display("FAIL stream_rd_valid k=%0d: got %b required %b", k, rd_valid, (k == 0) ? 4'b0000 : 4'b1000);
            end
            if (rd_valid[3]) run++;
        end
        cyc_begin();
        req = 4'b0000;
        mid();
        if (rd_valid[3]) run++;
        vec_cnt++;
        if (run !== 64) begin
            err_cnt++;
            $display("FAIL stream_rd_count: got %0d required %0d", run, 64);
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, busy, rd_valid} !== 9'd0) begin
            err_cnt++;
            $display("FAIL stream_release: got %b required %b", {gnt, busy, rd_valid}, 9'd0);
        end
    endtask

    task automatic test_burst_limit();
        do_reset();
        cyc_begin();
        req = 4'b0101; set_addr(0, 5); set_addr(2, 9);
        mid();
        for (int j = 1; j <= 8; j++) begin
            cyc_begin();
            mid();
            vec_cnt++;
            if ({gnt, memory_manage, ram_addr} !== {4'b0001, 2'd0, 6'd5}) begin
                err_cnt++;
                $display("FAIL pair_ctrl_burst j=%0d: got %b required %b", j, {gnt, memory_manage, ram_addr}, {4'b0001, 2'd0, 6'd5});
            end
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, busy, rd_valid} !== {4'b0000, 1'b0, 4'b0001}) begin
            err_cnt++;
            $display("FAIL pair_idle_gap: got %b required %b", {gnt, busy, rd_valid}, {4'b0000, 1'b0, 4'b0001});
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, memory_manage, ram_addr} !== {4'b0100, 2'd2, 6'd9}) begin
            err_cnt++;
            $display("FAIL pair_datapath_grant: got %b required %b", {gnt, memory_manage, ram_addr}, {4'b0100, 2'd2, 6'd9});
        end
        cyc_begin();
        req = 4'b0000;
        mid();
        vec_cnt++;
        if (rd_valid !== 4'b0100) begin
            err_cnt++;
            $display("FAIL pair_datapath_read: rd_valid got %b required %b", rd_valid, 4'b0100);
        end
        cyc_begin();
        mid();
    endtask

    task automatic test_write();
        cyc_begin();
        req = 4'b0100; datapath_we = 1'b1; set_addr(2, 12); datapath_wdata = 4'd7;
        mid();
        vec_cnt++;
        if (ram_wren !== 1'b0) begin
            err_cnt++;
            $display("FAIL write_before_grant: ram_wren got %b required %b", ram_wren, 1'b0);
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, ram_wren, ram_addr, ram_wdata} !== {4'b0100, 1'b1, 6'd12, 4'd7}) begin
            err_cnt++;
            $display("FAIL write_cycle: got %b required %b", {gnt, ram_wren, ram_addr, ram_wdata}, {4'b0100, 1'b1, 6'd12, 4'd7});
        end
        cyc_begin();
        req = 4'b0000; datapath_we = 1'b0;
        mid();
        vec_cnt++;
        if ({ram_wren, rd_valid} !== 5'd0) begin
            err_cnt++;
            $display("FAIL write_no_rd_valid: got %b required %b", {ram_wren, rd_valid}, 5'd0);
        end
        cyc_begin();
        req = 4'b0001; set_addr(0, 12); datapath_we = 1'b1;
        mid();
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, ram_wren} !== {4'b0001, 1'b0}) begin
            err_cnt++;
            $display("FAIL we_ignored_non_owner: got %b required %b", {gnt, ram_wren}, {4'b0001, 1'b0});
        end
        cyc_begin();
        req = 4'b0000; datapath_we = 1'b0;
        mid();
        vec_cnt++;
        if ({rd_valid, piece_read} !== {4'b0001, 4'd7}) begin
            err_cnt++;
            $display("FAIL readback_addr12: got %b required %b", {rd_valid, piece_read}, {4'b0001, 4'd7});
        end
        cyc_begin();
        mid();
    endtask

    task automatic test_rotate();
        int gap [4];
        int maxgap [4];
        logic [3:0] exp_gnt;
        do_reset();
        cyc_begin();
        req = 4'b1111; addr_in = '0;
        mid();
        for (int i = 0; i < 4; i++) begin
            gap[i] = 1;
            maxgap[i] = 1;
        end
        for (int j = 1; j <= 44; j++) begin
            cyc_begin();
            mid();
            exp_gnt = (((j - 1) % 9) == 8) ? 4'b0000 : (4'b0001 << (((j - 1) / 9) % 4));
            vec_cnt++;
            if (gnt !== exp_gnt) begin
                err_cnt++;
                $display("FAIL rotate j=%0d: gnt got %b required %b", j, gnt, exp_gnt);
            end
            for (int i = 0; i < 4; i++) begin
                if (gnt[i]) gap[i] = 0;
                else begin
                    gap[i]++;
                    if (gap[i] > maxgap[i]) maxgap[i] = gap[i];
                end
            end
        end
        cyc_begin();
        req = 4'b0000;
        mid();
        // The first low-grant cycle of each wait is the ordinary arbitration cycle.
        for (int i = 0; i < 4; i++) begin
            vec_cnt++;
            if (maxgap[i] - 1 > 3 * (MAX_BURST + 1)) begin
                err_cnt++;
                $display("FAIL rotate_wait_%0d: got %0d required at most %0d", i, maxgap[i] - 1, 3 * (MAX_BURST + 1));
            end
        end
        cyc_begin();
        mid();
    endtask

    task automatic test_early_drop_and_reset();
        cyc_begin();
        req = 4'b0010;
        mid();
        cyc_begin();
        mid();
        cyc_begin();
        req = 4'b1011;
        mid();
        cyc_begin();
        mid();
        vec_cnt++;
        if (gnt !== 4'b0010) begin
            err_cnt++;
            $display("FAIL drop_validator_owns: gnt got %b required %b", gnt, 4'b0010);
        end
        cyc_begin();
        req = 4'b1001;
        mid();
        vec_cnt++;
        if ({gnt, rd_valid} !== {4'b0010, 4'b0010}) begin
            err_cnt++;
            $display("FAIL drop_cycle: got %b required %b", {gnt, rd_valid}, {4'b0010, 4'b0010});
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, busy, rd_valid} !== 9'd0) begin
            err_cnt++;
            $display("FAIL drop_gnt_clear: got %b required %b", {gnt, busy, rd_valid}, 9'd0);
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, memory_manage} !== {4'b1000, 2'd3}) begin
            err_cnt++;
            $display("FAIL drop_view_next: got %b required %b", {gnt, memory_manage}, {4'b1000, 2'd3});
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if (rd_valid !== 4'b1000) begin
            err_cnt++;
            $display("FAIL view_read: rd_valid got %b required %b", rd_valid, 4'b1000);
        end
        reset = 1'b1;
        #1;
        vec_cnt++;
        if ({gnt, memory_manage, busy, rd_valid, ram_wren, ram_addr} !== 18'd0) begin
            err_cnt++;
            $display("FAIL reset_async: got %b required %b", {gnt, memory_manage, busy, rd_valid, ram_wren, ram_addr}, 18'd0);
        end
        // Validator plus datapath: rr reset to 0 must pick the validator.
        req = 4'b0110;
        @(posedge clk);
        mid();
        vec_cnt++;
        if ({gnt, rd_valid} !== 8'd0) begin
            err_cnt++;
            $display("FAIL reset_drops_rd_valid: got %b required %b", {gnt, rd_valid}, 8'd0);
        end
        cyc_begin();
        reset = 1'b0;
        mid();
        vec_cnt++;
        if (gnt !== 4'b0000) begin
            err_cnt++;
            $display("FAIL post_reset_idle: gnt got %b required %b", gnt, 4'b0000);
        end
        cyc_begin();
        mid();
        vec_cnt++;
        if ({gnt, memory_manage} !== {4'b0010, 2'd1}) begin
            err_cnt++;
            $display("FAIL post_reset_grant: got %b required %b", {gnt, memory_manage}, {4'b0010, 2'd1});
        end
        cyc_begin();
        req = 4'b0000;
        repeat (2) cyc_begin();
    endtask

    initial begin
        test_reset();
        test_stream();
        test_burst_limit();
        test_write();
        test_rotate();
        test_early_drop_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/board_memory_arbiter.md
# board_memory_arbiter

Round-robin arbiter for the single-port 64-square board RAM. It shares the RAM between the four agents that currently multiplex onto it: control, validator, datapath and view renderer. It replaces the static `memory_manage` select with a request/grant handshake that allows bursts and is starvation-free. It also tracks the RAM's one-cycle synchronous read latency, so each requester knows when `piece_read` holds its own data.

## Interface
Parameters:
- `ADDR_W`, default 6: board address width, `{x[2:0], y[2:0]}`.
- `DATA_W`, default 4: piece code width, 0–12 per the piece table.
- `MAX_BURST`, default 8: maximum consecutive accesses for one owner while any other request is pending. Legal range 1–255.

Ports:
- `clk`  in  1: system clock (CLOCK_50). One clock.
- `reset`  in  1: asynchronous, active-high reset.
- `req`  in  4: request per requester. Index 0 = control, 1 = validator, 2 = datapath, 3 = view.
- `addr_in`  in  4*ADDR_W: per-requester address. Slice i is `[i*ADDR_W +: ADDR_W]`.
- `datapath_we`  in  1: the datapath's access is a write.
- `datapath_wdata`  in  DATA_W: write data.
- `gnt`  out  4: one-hot registered grant, 0 when idle.
- `memory_manage`  out  2: index of the current owner, for the existing `memory_access` mux. Holds its last value when idle.
- `ram_addr`  out  ADDR_W: address to the RAM. Equals the owner's `addr_in` slice while granted, 0 when idle.
- `ram_wren`  out  1: RAM write enable.
- `ram_wdata`  out  DATA_W: passes through `datapath_wdata`.
- `rd_valid`  out  4: one-hot flag. Pulses the cycle the read data for requester i is on `piece_read`.
- `busy`  out  1: high while any grant is active.

## Operation
- States:
  - IDLE: no grant.
  - OWN: exactly one `gnt` bit high.
- IDLE, any `req` high: select the winner by round-robin, searching from `rr_ptr` upward with modulo 4. Register `gnt`, `memory_manage` and `busy`. Go to OWN.
- OWN:
  - Every cycle with the owner's `req` high is one access. `ram_addr` follows the owner's slice combinationally, so the requester may change the address every cycle (streaming).
  - `burst_cnt` (8 bits) increments on each access. It saturates at MAX_BURST.
- Release conditions, checked each OWN cycle:
  - (a) The owner's `req` is low. The current cycle is not an access.
  - (b) `burst_cnt == MAX_BURST-1` on an access cycle and any other `req` is high. That access completes.
- On release:
  - `gnt` clears next cycle.
  - `rr_ptr` becomes owner+1 mod 4.
  - `burst_cnt` clears.
  - Go to IDLE.
- There is always at least one idle cycle between owners. The owner never changes within a cycle.
- If no other requester is pending, the owner keeps the grant indefinitely. The burst limit is ignored.
- Writes:
  - `ram_wren = busy & gnt[2] & req[2] & datapath_we`.
  - A write has no `rd_valid`.
  - `datapath_we` is ignored when the datapath is not the owner.
- Reads: every non-write access with owner i sets `rd_valid[i]` on the next cycle. This applies even if the grant has since dropped.
- The owner drops `req` at any time. A requester that loses the grant to a forced release (b) must keep `req` high to re-queue.

## Timing
- Reset values (asynchronous): state IDLE, `gnt`=0, `memory_manage`=0, `busy`=0, `rr_ptr`=0, `burst_cnt`=0, `rd_valid`=0, `ram_wren`=0, `ram_addr`=0.
- Reset mid-burst: the pending `rd_valid` is dropped and no write occurs after reset asserts.
- Grant latency: `req` high in cycle t with the arbiter IDLE gives `gnt` high in t+1. The first access is in cycle t+1.
- Read latency: access in cycle a gives `rd_valid` in a+1, aligned with the RAM's registered output.
- Throughput:
  - One access per cycle within a burst.
  - Release to next grant costs 1 idle cycle.
  - Worst-case wait for a requester holding `req` is 3*(MAX_BURST+1) cycles.
- Simultaneous events:
  - Release (b) coinciding with the owner dropping `req`: treated as (a). `rr_ptr` still advances.
  - New requests arriving in the release cycle are arbitrated from IDLE in the following cycle.
- All outputs except `ram_addr`, `ram_wren` and `ram_wdata` are registered.

## Test plan
- Reset, then `req`=4'b1000 with `addr_in[3]` stepping 0..63 each cycle → `gnt`=4'b1000 after 1 cycle. `rd_valid[3]` is high for 64 consecutive cycles. `ram_addr` matches the stepped address with no gaps.
- `req`=4'b0101 asserted together from reset → control is granted first (`rr_ptr`=0). With MAX_BURST=8 the control grant ends after 8 accesses, then 1 idle cycle, then the datapath is granted.
- Datapath owner with `datapath_we`=1, addr 6'd12, wdata 4'd7 → `ram_wren`=1 for exactly that cycle. No `rd_valid`. A subsequent control read of addr 12 returns 7 with `rd_valid[0]`.
- All four `req` held high continuously → grants rotate 0,1,2,3,0. Each grant lasts 8 cycles, separated by 1 idle cycle. No requester waits more than 27 cycles.
- Validator owner drops `req` after 3 accesses, with the view pending → `gnt` clears the next cycle. `rr_ptr`=2 and the view is granted after 1 idle cycle.
- `reset` asserted mid-burst of the view, one cycle after an access → all outputs are 0 immediately. The expected `rd_valid[3]` never appears. After deassert, a pending `req`=4'b0010 is granted with `rr_ptr`=0.
